regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Dual-issue architectural register file with per-register busy tracking, serving the decode stage's register lookups and rename-lite destination mapping. Each cycle it answers four source reads (two per instruction) with data, a valid bit and a producer tag, and marks up to two destinations busy under freshly allocated tags. Two writeback ports, the same results that feed decode forwarding, write data back and clear busy only when the writeback tag matches the register's current producer tag.

## Interface
- XLEN, 32, register data width
- TAG_W, 6, producer tag width; also the width of the free-running allocation counter

- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rs1A, rs2A, rs1B, rs2B  input  5 each  source register addresses from decode
- s1A, s2A, s1B, s2B  output  XLEN each  source data
- rs1A_valid, rs2A_valid, rs1B_valid, rs2B_valid  output  1 each  1 = data is final, 0 = wait on tag
- tag1A, tag2A, tag1B, tag2B  output  TAG_W each  producer tag of each source; meaningful when valid=0
- map_en_A, map_en_B  input  1 each  mark rdA / rdB busy this cycle
- rdA, rdB  input  5 each  destination addresses
- dtagA, dtagB  output  TAG_W each  tag allocated to rdA / rdB this cycle
- wb_en_A, wb_en_B  input  1 each  writeback strobe
- wb_addr_A, wb_addr_B  input  5 each  writeback register
- wb_tag_A, wb_tag_B  input  TAG_W each  tag the writeback was issued under
- wb_data_A, wb_data_B  input  XLEN each  writeback data

## Operation
- State per register: data[XLEN], valid, tag[TAG_W]. One alloc counter, alloc_ctr[TAG_W].
- x0: reads always return 0, valid=1, tag=0. Map and writeback to x0 are ignored; a map to x0 consumes no tag and drives dtag=0.
- Tag allocation: an effective map is map_en=1 with rd!=0. A alone or B alone gets alloc_ctr. When both are effective, A gets alloc_ctr and B gets alloc_ctr+1. alloc_ctr advances by the number of effective maps, modulo 2^TAG_W.
- Map: sets valid=0 and tag=dtag for rd. If rdA==rdB (both effective), B is younger and its tag is stored.
- Writeback: when wb_en=1, addr!=0 and wb_tag==tag[addr], data is written and valid is set to 1. A tag mismatch means a newer producer is pending and the writeback is dropped entirely.
- Map and matching writeback to the same register in the same cycle: data is written, but the map wins (valid=0, new tag).
- Two writebacks to the same register with distinct tags: at most one matches. If both match (tag aliasing), port B wins.
- Read path (combinational), in priority order:
  1. Intra-pair hazard: B's source equals an effective rdA → valid=0, tag=dtagA, data=don't-care (drive 0).
  2. Bypass: a matching writeback to that register this cycle → data=wb_data, valid=1. This applies to both A and B sources.
  3. Otherwise the stored data, valid and tag.
- A sources never see B's map (A is older).
- System constraint: no more than 2^TAG_W − 1 maps are issued while a producer is outstanding. The block does not detect aliasing.

## Timing
- Reset (async assert, sync-released state): all data=0, valid=1, tag=0, alloc_ctr=0.
- Outputs driven from reset state: s*=0, rs*_valid=1, tag*=0, dtag*=0.
- All read outputs and dtag* are combinational in the same cycle as their inputs, with zero latency.
- Map and writeback take effect at the next rising edge. A read in cycle N+1 sees a map issued in cycle N.
- Writeback is visible the same cycle through the bypass, and from storage from cycle N+1.
- Reset asserted mid-operation discards all busy state and restarts tag allocation at 0.

## Test plan
- Reset, then read x5 on all four ports → data 0, valid 1, tag 0. Read x0 after a wb attempt of 0xDEAD to x0 → still 0, valid 1.
- map_en_A with rdA=3 at alloc_ctr=0 → dtagA=0. Next cycle rs1A=3 → valid 0, tag 0. wb x3 with tag 0 and data 0x1234 → same-cycle bypass gives valid 1 and 0x1234; next cycle stored value 0x1234, valid 1.
- WAW: map x4 (tag 1), then map x4 (tag 2). wb x4 with tag 1 and data 0xAA is dropped: x4 stays valid 0, tag 2. wb with tag 2 and data 0xBB → x4 valid, 0xBB.
- Pair hazard: map_en_A with rdA=7, rs1B=7 in the same cycle → rs1B_valid 0, tag1B=dtagA. rs1A=7 in that cycle → old contents, valid 1.
- Dual map, same rd: rdA=rdB=9 at alloc_ctr=5 → dtagA=5, dtagB=6. Next cycle x9 tag=6 and alloc_ctr=7. A wb with tag 5 is ignored.
- Tag wrap and reset: start at alloc_ctr=63 and dual map → tags 63 and 0, alloc_ctr=1. Assert rst_n low while x9 is busy → x9 valid 1, data 0, alloc_ctr 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-issue register file with per-register busy/tag tracking,
// tag allocation for up to two destinations per cycle and tag-checked writeback.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1A,
  input  logic [4:0]       rs2A,
  input  logic [4:0]       rs1B,
  input  logic [4:0]       rs2B,
  output logic [XLEN-1:0]  s1A,
  output logic [XLEN-1:0]  s2A,
  output logic [XLEN-1:0]  s1B,
  output logic [XLEN-1:0]  s2B,
  output logic             rs1A_valid,
  output logic             rs2A_valid,
  output logic             rs1B_valid,
  output logic             rs2B_valid,
  output logic [TAG_W-1:0] tag1A,
  output logic [TAG_W-1:0] tag2A,
  output logic [TAG_W-1:0] tag1B,
  output logic [TAG_W-1:0] tag2B,
  input  logic             map_en_A,
  input  logic             map_en_B,
  input  logic [4:0]       rdA,
  input  logic [4:0]       rdB,
  output logic [TAG_W-1:0] dtagA,
  output logic [TAG_W-1:0] dtagB,
  input  logic             wb_en_A,
  input  logic             wb_en_B,
  input  logic [4:0]       wb_addr_A,
  input  logic [4:0]       wb_addr_B,
  input  logic [TAG_W-1:0] wb_tag_A,
  input  logic [TAG_W-1:0] wb_tag_B,
  input  logic [XLEN-1:0]  wb_data_A,
  input  logic [XLEN-1:0]  wb_data_B
);
  logic [XLEN-1:0]  data [32];
  logic [TAG_W-1:0] tag [32];
  logic [31:0]      valid;
  logic [TAG_W-1:0] alloc_ctr;
  logic             eff_a, eff_b, hit_a, hit_b;
  logic [4:0]       ra [4];
  logic [XLEN-1:0]  rd_s [4];
  logic             rd_v [4];
  logic [TAG_W-1:0] rd_t [4];

  assign eff_a = map_en_A && rdA != '0;
  assign eff_b = map_en_B && rdB != '0;
  assign dtagA = eff_a ? alloc_ctr : '0;
  assign dtagB = eff_b ? alloc_ctr + TAG_W'(eff_a) : '0;
  // x0 is never written, so its reset contents (0, valid, tag 0) serve all x0 reads
  assign hit_a = wb_en_A && wb_addr_A != '0 && wb_tag_A == tag[wb_addr_A];
  assign hit_b = wb_en_B && wb_addr_B != '0 && wb_tag_B == tag[wb_addr_B];
  assign ra = '{rs1A, rs2A, rs1B, rs2B};

  for (genvar i = 0; i < 4; i++) begin : g_rd
    localparam bit IS_B = i >= 2;
    logic haz, byp_a, byp_b;
    assign haz = IS_B && eff_a && ra[i] == rdA;
    assign byp_a = hit_a && wb_addr_A == ra[i];
    assign byp_b = hit_b && wb_addr_B == ra[i];
    assign rd_s[i] = haz ? '0 : byp_b ? wb_data_B : byp_a ? wb_data_A : data[ra[i]];
    assign rd_v[i] = !haz && (byp_a || byp_b || valid[ra[i]]);
    assign rd_t[i] = haz ? dtagA : tag[ra[i]];
  end

  assign {s1A, s2A, s1B, s2B} = {rd_s[0], rd_s[1], rd_s[2], rd_s[3]};
  assign {rs1A_valid, rs2A_valid, rs1B_valid, rs2B_valid} = {rd_v[0], rd_v[1], rd_v[2], rd_v[3]};
  assign {tag1A, tag2A, tag1B, tag2B} = {rd_t[0], rd_t[1], rd_t[2], rd_t[3]};

  // later assignments win: wb B over wb A, then maps over writeback, map B over map A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin
        data[k] <= '0;
        tag[k] <= '0;
      end
      valid <= '1;
      alloc_ctr <= '0;
    end else begin
      if (hit_a) begin
        data[wb_addr_A] <= wb_data_A;
        valid[wb_addr_A] <= 1'b1;
      end
      if (hit_b) begin
        data[wb_addr_B] <= wb_data_B;
        valid[wb_addr_B] <= 1'b1;
      end
      if (eff_a) begin
        valid[rdA] <= 1'b0;
        tag[rdA] <= dtagA;
      end
      if (eff_b) begin
        valid[rdB] <= 1'b0;
        tag[rdB] <= dtagB;
      end
      alloc_ctr <= alloc_ctr + TAG_W'(eff_a) + TAG_W'(eff_b);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random traffic; a reference register-file model
// predicts each cycle's outputs into a queue that a negedge monitor checks.
module tb_regfile_scoreboard;
  typedef struct packed {
    logic [3:0][4:0] rs;
    logic ma, mb;
    logic [4:0] rda, rdb;
    logic wa, wb;
    logic [4:0] waa, wab;
    logic [5:0] wta, wtb;
    logic [31:0] wda, wdb;
  } stim_t;
  typedef struct packed {
    logic [3:0][31:0] s;
    logic [3:0] v;
    logic [3:0][5:0] t;
    logic [5:0] da, db;
  } exp_t;

  logic clk = 0, rst_n = 0;
  stim_t st = '0;
  logic [31:0] ds [4];
  logic dv [4];
  logic [5:0] dt [4];
  logic [5:0] dta, dtb;
  exp_t q [$];
  int checks = 0, errors = 0;

  logic [31:0] md [32];
  bit mv [32];
  logic [5:0] mt [32];
  int mctr;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rs1A(st.rs[0]), .rs2A(st.rs[1]), .rs1B(st.rs[2]), .rs2B(st.rs[3]),
    .s1A(ds[0]), .s2A(ds[1]), .s1B(ds[2]), .s2B(ds[3]),
    .rs1A_valid(dv[0]), .rs2A_valid(dv[1]), .rs1B_valid(dv[2]), .rs2B_valid(dv[3]),
    .tag1A(dt[0]), .tag2A(dt[1]), .tag1B(dt[2]), .tag2B(dt[3]),
    .map_en_A(st.ma), .map_en_B(st.mb), .rdA(st.rda), .rdB(st.rdb),
    .dtagA(dta), .dtagB(dtb),
    .wb_en_A(st.wa), .wb_en_B(st.wb), .wb_addr_A(st.waa), .wb_addr_B(st.wab),
    .wb_tag_A(st.wta), .wb_tag_B(st.wtb), .wb_data_A(st.wda), .wb_data_B(st.wdb)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      md[i] = 0;
      mv[i] = 1;
      mt[i] = 0;
    end
    mctr = 0;
  endtask

  // Predict this cycle's outputs from the architectural state, then commit the cycle.
  task automatic issue(input stim_t s, input bit commit);
    exp_t e;
    bit ea, eb, ha, hb;
    int r;
    ea = s.ma && s.rda != 0;
    eb = s.mb && s.rdb != 0;
    ha = s.wa && s.waa != 0 && s.wta == mt[s.waa];
    hb = s.wb && s.wab != 0 && s.wtb == mt[s.wab];
    e.da = ea ? 6'(mctr) : 6'd0;
    e.db = eb ? 6'((mctr + int'(ea)) % 64) : 6'd0;
    for (int k = 0; k < 4; k++) begin
      r = int'(s.rs[k]);
      e.t[k] = mt[r];
      if (r == 0) begin
        e.s[k] = 0; e.v[k] = 1; e.t[k] = 0;
      end else if (k >= 2 && ea && r == int'(s.rda)) begin
        e.s[k] = 0; e.v[k] = 0; e.t[k] = e.da;
      end else if (hb && r == int'(s.wab)) begin
        e.s[k] = s.wdb; e.v[k] = 1;
      end else if (ha && r == int'(s.waa)) begin
        e.s[k] = s.wda; e.v[k] = 1;
      end else begin
        e.s[k] = md[r]; e.v[k] = mv[r];
      end
    end
    q.push_back(e);
    if (commit) begin
      if (ha) begin md[s.waa] = s.wda; mv[s.waa] = 1; end
      if (hb) begin md[s.wab] = s.wdb; mv[s.wab] = 1; end
      if (ea) begin mv[s.rda] = 0; mt[s.rda] = e.da; end
      if (eb) begin mv[s.rdb] = 0; mt[s.rdb] = e.db; end
      mctr = (mctr + int'(ea) + int'(eb)) % 64;
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = 1;
    st = s;
    issue(s, 1);
  endtask

  task automatic reset_cycle(input stim_t s);
    @(posedge clk);
    #1;
    rst_n = 0;
    st = s;
    model_reset();
    issue(s, 0);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", name, k, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk("data", k, ds[k], e.s[k]);
        chk("valid", k, 32'(dv[k]), 32'(e.v[k]));
        if (!e.v[k]) chk("tag", k, 32'(dt[k]), 32'(e.t[k]));
      end
      chk("dtagA", 0, 32'(dta), 32'(e.da));
      chk("dtagB", 0, 32'(dtb), 32'(e.db));
    end
  end

  function automatic stim_t rd4(input int a, input int b, input int c, input int d);
    stim_t s = '0;
    s.rs[0] = 5'(a); s.rs[1] = 5'(b); s.rs[2] = 5'(c); s.rs[3] = 5'(d);
    return s;
  endfunction

  initial begin
    stim_t s;
    model_reset();
    reset_cycle(rd4(5, 5, 5, 5));
    s = rd4(5, 0, 5, 0); s.wa = 1; s.waa = 0; s.wda = 32'hDEAD; step(s);
    step(rd4(0, 0, 0, 0));
    s = rd4(0, 0, 0, 0); s.ma = 1; s.rda = 3; step(s);
    step(rd4(3, 3, 3, 3));
    s = rd4(3, 0, 3, 0); s.wa = 1; s.waa = 3; s.wta = 0; s.wda = 32'h1234; step(s);
    step(rd4(3, 3, 3, 3));
    s = rd4(0, 0, 0, 0); s.ma = 1; s.rda = 4; step(s);
    s = rd4(4, 0, 4, 0); s.ma = 1; s.rda = 4; step(s);
    s = rd4(4, 4, 4, 4); s.wa = 1; s.waa = 4; s.wta = 1; s.wda = 32'hAA; step(s);
    s = rd4(4, 4, 4, 4); s.wb = 1; s.wab = 4; s.wtb = 2; s.wdb = 32'hBB; step(s);
    step(rd4(4, 4, 4, 4));
    s = rd4(7, 7, 7, 0); s.ma = 1; s.rda = 7; step(s);
    s = rd4(7, 0, 7, 0); s.ma = 1; s.rda = 1; step(s);
    s = rd4(9, 9, 9, 9); s.ma = 1; s.mb = 1; s.rda = 9; s.rdb = 9; step(s);
    s = rd4(9, 9, 9, 9); s.wa = 1; s.waa = 9; s.wta = 5; s.wda = 32'h55; step(s);
    s = rd4(9, 0, 0, 9); s.ma = 1; s.rda = 0; s.mb = 1; s.rdb = 0; step(s);
    while (mctr != 63) begin
      s = rd4(2, 9, 2, 9); s.ma = 1; s.rda = 2; step(s);
    end
    s = rd4(9, 10, 9, 10); s.ma = 1; s.mb = 1; s.rda = 9; s.rdb = 10; step(s);
    s = rd4(9, 10, 9, 10); s.ma = 1; s.rda = 11; step(s);
    reset_cycle(rd4(9, 10, 9, 10));
    s = rd4(9, 10, 11, 9); s.ma = 1; s.rda = 12; step(s);
    for (int n = 0; n < 600; n++) begin
      s = rd4($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      s.ma = 1'($urandom_range(0, 1)); s.rda = 5'($urandom_range(0, 7));
      s.mb = 1'($urandom_range(0, 1)); s.rdb = 5'($urandom_range(0, 7));
      s.wa = $urandom_range(0, 9) < 6; s.waa = 5'($urandom_range(0, 7));
      s.wb = $urandom_range(0, 9) < 6; s.wab = 5'($urandom_range(0, 7));
      s.wta = $urandom_range(0, 9) < 7 ? mt[s.waa] : 6'($urandom);
      s.wtb = $urandom_range(0, 9) < 7 ? mt[s.wab] : 6'($urandom);
      s.wda = $urandom; s.wdb = $urandom;
      if (n == 300) reset_cycle(rd4(1, 2, 3, 4));
      else step(s);
    end
    step(rd4(1, 2, 3, 4));
    for (int n = 0; n < 10 && q.size() != 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
